// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and decode helpers.
// The instruction decoder and the execute stage both import this package.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // True for the three ops that go through the serial shifter
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add/sub, bitwise logic and set-less-than.
// Shift codes and unused codes give zero here; shifts are handled serially
// by the execute stage.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result
);

  // Select the operation; add/sub wrap naturally at XLEN bits
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshakes on both sides.
// Single-cycle ops finish one cycle after accept; shifts walk one bit per
// cycle through a serial shifter held in the result register.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_ctrl,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [TAG_W-1:0]  rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic [TAG_W-1:0]  out_rd_addr,
  output logic              busy
);

  alu_state_t          state;
  logic [3:0]          op_q;
  logic [SHAMT_W-1:0]  sh_cnt;
  logic                sign_q;
  logic [XLEN-1:0]     result_q;
  logic [TAG_W-1:0]    rd_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [XLEN-1:0]     comb_result;
  logic [XLEN-1:0]     shift_next;
  logic [SHAMT_W-1:0]  shamt;
  logic                accept;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (comb_result)
  );

  assign shamt       = src_b[SHAMT_W-1:0];
  assign in_ready    = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign out_rd_addr = rd_q;

  // One-bit step of the serial shifter; SRA refills with the captured sign
  always_comb begin
    shift_next = result_q;
    case (op_q)
      ALU_SLL: shift_next = {result_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_next = {1'b0, result_q[XLEN-1:1]};
      ALU_SRA: shift_next = {sign_q, result_q[XLEN-1:1]};
      default: shift_next = result_q;
    endcase
  end

  // Control FSM with registered out_valid/busy; a DONE-state accept starts the next op with no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= ALU_ADD;
      sh_cnt      <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q   <= alu_ctrl;
            rd_q   <= rd_addr;
            sign_q <= src_a[XLEN-1];
            if (is_shift_op(alu_ctrl) && (shamt != '0)) begin
              state       <= ST_SHIFT;
              result_q    <= src_a;
              sh_cnt      <= shamt;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              state       <= ST_DONE;
              result_q    <= is_shift_op(alu_ctrl) ? src_a : comb_result;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          result_q <= shift_next;
          sh_cnt   <= sh_cnt - 1'b1;
          if (sh_cnt == 1) begin
            state       <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: the driver pushes expected results, a
// monitor pops and compares them whenever a result is handed over.
module tb_alu_exec;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_ctrl = '0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic [4:0]      rd_addr = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic [4:0]      out_rd_addr;
  logic            busy;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   head_timed = 1'b0;
  int   waits;

  alu_exec #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .src_a       (src_a),
    .src_b       (src_b),
    .rd_addr     (rd_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_rd_addr (out_rd_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                               input string name, output int nwait);
    exp_t e;
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    rd_addr  = rd;
    nwait    = 0;
    #1;
    while (!in_ready && nwait < 200) begin
      @(negedge clk);
      #1;
      nwait++;
    end
    if (!in_ready) begin
      checkOutput({name, " accept timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      e.res  = exp_res;
      e.rd   = rd;
      e.acc  = cyc;
      e.lat  = lat;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
    end
  endtask

  // Monitor: checks latency when a result first appears, contents when it is taken
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) begin
        checkOutput("idle out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (!head_timed) begin
          head_timed = 1'b1;
          checkOutput({sb[0].name, " latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
        if (out_ready) begin
          e = sb.pop_front();
          head_timed = 1'b0;
          checkOutput({e.name, " result"}, result, e.res);
          checkOutput({e.name, " tag"}, 32'(out_rd_addr), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset out_rd_addr", 32'(out_rd_addr), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;

    applyStimulus(4'd0, 32'd5,          32'd7,          5'd3,  32'd12,         1,  "ADD",      waits);
    applyStimulus(4'd1, 32'd0,          32'd1,          5'd4,  32'hFFFFFFFF,   1,  "SUB",      waits);
    applyStimulus(4'd8, 32'hFFFFFFFF,   32'd1,          5'd5,  32'd1,          1,  "SLT",      waits);
    applyStimulus(4'd9, 32'hFFFFFFFF,   32'd1,          5'd6,  32'd0,          1,  "SLTU",     waits);
    applyStimulus(4'd2, 32'hF0F0F0F0,   32'hFF00FF00,   5'd7,  32'h0FF00FF0,   1,  "XOR",      waits);
    applyStimulus(4'd3, 32'h12340000,   32'h00005678,   5'd8,  32'h12345678,   1,  "OR",       waits);
    applyStimulus(4'd4, 32'hDEADBEEF,   32'h0000FFFF,   5'd9,  32'h0000BEEF,   1,  "AND",      waits);
    applyStimulus(4'd0, 32'hFFFFFFFF,   32'd2,          5'd10, 32'd1,          1,  "ADD wrap", waits);
    applyStimulus(4'hC, 32'h12345678,   32'h9ABCDEF0,   5'd11, 32'd0,          1,  "code 0xC", waits);
    applyStimulus(4'd5, 32'd1,          32'h21,         5'd12, 32'd2,          2,  "SLL 0x21", waits);
    applyStimulus(4'd6, 32'h80000000,   32'd31,         5'd13, 32'd1,          32, "SRL 31",   waits);
    applyStimulus(4'd7, 32'h80000001,   32'h20,         5'd14, 32'h80000001,   1,  "SRA 0",    waits);
    applyStimulus(4'd7, 32'h80000000,   32'd4,          5'd15, 32'hF8000000,   5,  "SRA 4",    waits);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("SRA busy", 32'(busy), 32'd1);
      checkOutput("SRA in_ready", 32'(in_ready), 32'd0);
      checkOutput("SRA out_valid low", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    checkOutput("SRA busy end", 32'(busy), 32'd0);
    checkOutput("SRA out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);

    out_ready = 1'b0;
    applyStimulus(4'd0, 32'd100, 32'd23, 5'd9, 32'd123, 1, "ADD held", waits);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("held out_valid", 32'(out_valid), 32'd1);
      checkOutput("held result", result, 32'd123);
      checkOutput("held out_rd_addr", 32'(out_rd_addr), 32'd9);
      @(negedge clk);
    end
    out_ready = 1'b1;
    applyStimulus(4'd2, 32'hAAAA5555, 32'hFFFF0000, 5'd17, 32'h55555555, 1, "XOR nobubble", waits);
    checkOutput("no bubble wait", 32'(waits), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    applyStimulus(4'd5, 32'd1, 32'd10, 5'd20, 32'd1024, 11, "SLL 10", waits);
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'd0;
    src_a    = 32'd1;
    src_b    = 32'd1;
    sb.delete();
    head_timed = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst shift out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst shift busy", 32'(busy), 32'd0);
    checkOutput("rst shift in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst shift result", result, 32'd0);
    repeat (12) @(negedge clk);

    applyStimulus(4'd1, 32'd50, 32'd8, 5'd31, 32'd42, 1, "SUB after rst", waits);
    in_valid = 1'b0;

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
